add_sub_seq: RTL

//  Multi-cycle WIDTH-bit adder/subtractor. Processes operands in two SLICE-bit halves

---
 rtl/add_sub_seq.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/add_sub_seq.sv
// ---------------------------------------------------------------------------
// add_sub_seq
// Multi-cycle WIDTH-bit adder/subtractor. One operand beat is accepted from an
// upstream producer, the addition is carried out in two SLICE-bit halves
// through a single shared ripple_adder slice, and one result beat is returned
// downstream. The carry between the two halves is held in a register.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block can accept an operand beat (idle)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   sub        in   1      0: A+B, 1: A-B
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of the MSB (subtract: 1 = no borrow)
//   ovf        out  1      signed overflow, only when ADD_SUB_SEQ_OVF_EN is defined
//
// Configuration:
//   ADD_SUB_SEQ_OVF_EN  when defined, adds the registered signed-overflow
//                       output ovf, updated together with cout.
//
// WIDTH must equal 2*SLICE.
// ---------------------------------------------------------------------------

// Plain N-bit ripple-carry adder slice, the shared arithmetic resource.
module ripple_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  // Bit-serial carry chain, one full adder per bit.
  always_comb begin
    logic carry;
    carry = cin;
    s     = '0;
    for (int i = 0; i < N; i++) begin
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    cout = carry;
  end

endmodule

module add_sub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADD_SUB_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;
  logic             carry_q;

  logic [SLICE-1:0] slice_x;
  logic [SLICE-1:0] slice_y;
  logic [SLICE-1:0] slice_s;
  logic             slice_c;

  // Accepting only when idle keeps exactly one operation in flight.
  assign in_ready = (state == IDLE);

  // The shared slice sees the high halves in HI and the low halves otherwise.
  always_comb begin
    slice_x = a_q[SLICE-1:0];
    slice_y = bx_q[SLICE-1:0];
    if (state == HI) begin
      slice_x = a_q[WIDTH-1:SLICE];
      slice_y = bx_q[WIDTH-1:SLICE];
    end
  end

  ripple_adder #(.N(SLICE)) u_slice (
    .x    (slice_x),
    .y    (slice_y),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE -> LO -> HI -> DONE, waiting in IDLE for an
  // operand and in DONE for the downstream handshake.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid) next_state = LO;
      LO:   next_state = HI;
      HI:   next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers. Subtraction is a + ~b + 1: b is inverted at capture
  // and the +1 enters as the initial carry into the low slice. sum/cout keep
  // their last value after the result handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      bx_q      <= '0;
      carry_q   <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            bx_q    <= b ^ {WIDTH{sub}};
            carry_q <= sub;
          end
        end
        LO: begin
          sum[SLICE-1:0] <= slice_s;
          carry_q        <= slice_c;
        end
        HI: begin
          sum[WIDTH-1:SLICE] <= slice_s;
          cout               <= slice_c;
          out_valid          <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADD_SUB_SEQ_OVF_EN
  // Signed overflow: both effective operands share a sign that the result
  // does not. The result MSB is the top bit of the high slice sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == HI) begin
      ovf <= (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (slice_s[SLICE-1] != a_q[WIDTH-1]);
    end
  end
`endif

endmodule
